mem_access_scheduler: RTL and testbench

- Sequences the single-port data RAM and shares it between two requesters: the instruction-fetch port and the data port driven by memory control (LDR/STR/ADR traffic).
- Latches each granted request, issues one RAM cycle, and waits out the fixed RAM read latency. It then returns read data with a one-cycle ack.
- Data requests have priority. A streak limit prevents fetch starvation.

---
 rtl/mem_access_scheduler_if.sv | 35 +++
 rtl/mem_access_scheduler.sv | 98 +++++++++
 tb/tb_mem_access_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_scheduler_if.sv
// Requester and RAM-side signals of the memory access scheduler.
// The scheduler takes the slave modport and the requesters/RAM the master.
interface mem_access_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_ack, if_rdata, d_ack, d_err, d_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_ack, if_rdata, d_ack, d_err, d_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mem_access_scheduler.sv
// Shares a single-port RAM between instruction fetch and the data port.
// Data has priority; a streak limit guarantees fetch progress.
module mem_access_scheduler #(
    parameter int RAM_LAT    = 1,
    parameter int ADDR_W     = 16,
    parameter int MAX_STREAK = 4
) (
    input logic                  clk,
    input logic                  reset,
    mem_access_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              own_d;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic [3:0]        cnt;
    logic [3:0]        streak;

    logic grant_d;
    logic oor;

    // Fetch only overtakes data once data has won MAX_STREAK times in a row.
    assign grant_d = bus.d_req && !(bus.if_req && streak == 4'(MAX_STREAK));
    assign oor     = (bus.d_addr >> ADDR_W) != 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            own_d      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt        <= '0;
            streak     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        own_d <= grant_d;
                        if (grant_d) begin
                            addr_q  <= bus.d_addr[ADDR_W-1:0];
                            we_q    <= bus.d_we;
                            wdata_q <= bus.d_wdata;
                            err_q   <= oor;
                            streak  <= !bus.if_req ? 4'd0 :
                                       (streak == 4'(MAX_STREAK)) ? streak : streak + 4'd1;
                            state   <= oor ? S_DONE : S_ISSUE;
                        end else begin
                            addr_q  <= bus.if_addr[ADDR_W-1:0];
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            err_q   <= 1'b0;
                            streak  <= '0;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= 4'(RAM_LAT);
                    state <= we_q ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Last wait cycle: RAM data is valid now.
                    if (cnt == 4'd1) begin
                        if (own_d) d_rdata_q  <= bus.ram_rdata;
                        else       if_rdata_q <= bus.ram_rdata;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_en    = (state == S_ISSUE);
    assign bus.ram_we    = bus.ram_en && we_q;
    assign bus.ram_addr  = bus.ram_en ? addr_q : '0;
    assign bus.ram_wdata = bus.ram_en ? wdata_q : '0;
    assign bus.if_ack    = (state == S_DONE) && !own_d;
    assign bus.d_ack     = (state == S_DONE) && own_d;
    assign bus.d_err     = (state == S_DONE) && own_d && err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench: a table of single transactions on a RAM_LAT=1 instance,
// plus arbitration, back-to-back and mid-transaction reset sequences.
module tb_mem_access_scheduler;
    logic clk = 1'b0;
    logic rst1, rst3;
    always #5 clk = ~clk;

    mem_access_scheduler_if #(.ADDR_W(16)) b1();
    mem_access_scheduler_if #(.ADDR_W(16)) b3();

    mem_access_scheduler #(.RAM_LAT(1), .ADDR_W(16), .MAX_STREAK(4)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1));
    mem_access_scheduler #(.RAM_LAT(3), .ADDR_W(16), .MAX_STREAK(4)) dut3 (
        .clk(clk), .reset(rst3), .bus(b3));

    // RAM model: write on the strobe edge, read data appears RAM_LAT cycles later.
    logic [31:0] mem [256];
    logic [31:0] p1;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h04] <= 32'h1111_0004;
            mem[8'h08] <= 32'h2222_0008;
            mem[8'h10] <= 32'hDEAD_BEEF;
        end else if (b1.ram_en && b1.ram_we) begin
            mem[b1.ram_addr[7:0]] <= b1.ram_wdata;
        end
        p1    <= (b1.ram_en && !b1.ram_we) ? mem[b1.ram_addr[7:0]] : 32'h0BAD_0BAD;
        p3[0] <= (b3.ram_en && !b3.ram_we) ? mem[b3.ram_addr[7:0]] : 32'h0BAD_0BAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.ram_rdata = p1;
    assign b3.ram_rdata = p3[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          en_cnt;
    } vec_t;

    vec_t vt [8];

    // Issue one request in the current (IDLE) cycle N and check the whole transaction.
    task automatic run1(input vec_t v, input int idx);
        int lat = -1;
        int en_cnt = 0;
        int en_k = -1;
        logic [15:0] ra = '0;
        logic rw = 1'b0;
        logic [31:0] rwd = '0;
        logic [31:0] rd = '0;
        logic err_ack = 1'b0;
        logic other = 1'b0;
        if (v.fetch) begin
            b1.if_req = 1'b1; b1.if_addr = v.addr;
        end else begin
            b1.d_req = 1'b1; b1.d_we = v.we; b1.d_addr = v.addr; b1.d_wdata = v.wdata;
        end
        for (int k = 0; k < 30 && lat < 0; k++) begin
            @(negedge clk);
            if (b1.ram_en) begin
                en_cnt++; en_k = k; ra = b1.ram_addr; rw = b1.ram_we; rwd = b1.ram_wdata;
            end
            if (v.fetch ? b1.d_ack : b1.if_ack) other = 1'b1;
            if (b1.d_err && !b1.d_ack) other = 1'b1;
            if (v.fetch ? b1.if_ack : b1.d_ack) begin
                lat = k;
                err_ack = b1.d_err;
                rd = v.fetch ? b1.if_rdata : b1.d_rdata;
                b1.if_req = 1'b0;
                b1.d_req = 1'b0;
            end
        end
        b1.if_req = 1'b0;
        b1.d_req = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d err", idx), 32'(err_ack), 32'(v.err));
        chk($sformatf("v%0d ram_en count", idx), en_cnt, v.en_cnt);
        chk($sformatf("v%0d stray ack/err", idx), 32'(other), 32'd0);
        if (en_cnt > 0 && v.en_cnt > 0) begin
            chk($sformatf("v%0d ram_en cycle", idx), en_k, 1);
            chk($sformatf("v%0d ram_addr", idx), 32'(ra), 32'(v.addr[15:0]));
            chk($sformatf("v%0d ram_we", idx), 32'(rw), 32'(v.we));
            if (v.we) chk($sformatf("v%0d ram_wdata", idx), rwd, v.wdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] order [10];
        string exp_order;
        int acks, dual, k1, k2, lat3, ack3;
        logic [31:0] d1, d2;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, 1};
        vt[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1'b0, 32'hDEAD_BEEF, 1};
        vt[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h1234_5678, 1};
        vt[3] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,         1, 1'b1, 32'h1234_5678, 0};
        vt[4] = '{1'b0, 1'b1, 32'hFFFF_0020, 32'hCAFE_F00D, 1, 1'b1, 32'h1234_5678, 0};
        vt[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         3, 1'b0, 32'h1111_0004, 1};
        vt[6] = '{1'b1, 1'b0, 32'h0001_0008, 32'h0,         3, 1'b0, 32'h2222_0008, 1};
        vt[7] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h1234_5678, 1};

        rst1 = 1'b1; rst3 = 1'b1;
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst if_ack", 32'(b1.if_ack), 32'd0);
        chk("rst d_ack", 32'(b1.d_ack), 32'd0);
        chk("rst d_err", 32'(b1.d_err), 32'd0);
        chk("rst ram_en", 32'(b1.ram_en), 32'd0);
        chk("rst ram_we", 32'(b1.ram_we), 32'd0);
        chk("rst ram_addr", 32'(b1.ram_addr), 32'd0);
        chk("rst ram_wdata", b1.ram_wdata, 32'd0);
        chk("rst if_rdata", b1.if_rdata, 32'd0);
        chk("rst d_rdata", b1.d_rdata, 32'd0);
        chk("rst busy", 32'(b1.busy), 32'd0);
        chk("rst3 busy", 32'(b3.busy), 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0;

        for (int i = 0; i < 8; i++) run1(vt[i], i);

        // Both requesters held: data wins four times, then fetch.
        exp_order = "DDDDFDDDDF";
        for (int i = 0; i < 10; i++) order[i] = 8'h0;
        acks = 0; dual = 0;
        b1.d_we = 0; b1.d_addr = 32'h10; b1.if_addr = 32'h4;
        b1.d_req = 1; b1.if_req = 1;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            @(negedge clk);
            if (b1.d_ack && b1.if_ack) dual++;
            if (b1.d_ack) begin order[acks] = "D"; acks++; end
            else if (b1.if_ack) begin order[acks] = "F"; acks++; end
            if (acks == 10) begin b1.d_req = 0; b1.if_req = 0; end
        end
        b1.d_req = 0; b1.if_req = 0;
        for (int i = 0; i < 10; i++)
            chk($sformatf("grant %0d", i), 32'(order[i]), 32'(exp_order.getc(i)));
        chk("dual ack", dual, 0);
        @(posedge clk); #1;

        // Back-to-back fetches; address changed right after the first grant.
        k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        b1.if_addr = 32'h4; b1.if_req = 1;
        for (int k = 0; k < 40 && k2 < 0; k++) begin
            @(negedge clk);
            if (k == 1) b1.if_addr = 32'h8;
            if (b1.if_ack) begin
                if (k1 < 0) begin k1 = k; d1 = b1.if_rdata; end
                else begin k2 = k; d2 = b1.if_rdata; b1.if_req = 0; end
            end
        end
        b1.if_req = 0;
        chk("b2b first ack", k1, 3);
        chk("b2b spacing", k2 - k1, 4);
        chk("b2b data0", d1, 32'h1111_0004);
        chk("b2b data1", d2, 32'h2222_0008);
        @(posedge clk); #1;

        // RAM_LAT=3 fetch aborted by reset in its second WAIT cycle.
        b3.if_addr = 32'h8; b3.if_req = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) chk("r3 issue strobe", 32'(b3.ram_en), 32'd1);
        end
        rst3 = 1'b1; b3.if_req = 0;
        @(negedge clk);
        chk("r3 busy after reset", 32'(b3.busy), 32'd0);
        chk("r3 if_ack after reset", 32'(b3.if_ack), 32'd0);
        chk("r3 ram_en after reset", 32'(b3.ram_en), 32'd0);
        chk("r3 ram_addr after reset", 32'(b3.ram_addr), 32'd0);
        chk("r3 if_rdata after reset", b3.if_rdata, 32'd0);
        rst3 = 1'b0;
        ack3 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b3.if_ack) ack3++;
        end
        chk("r3 no ack after abort", ack3, 0);
        @(posedge clk); #1;
        lat3 = -1; d1 = '0;
        b3.if_addr = 32'h4; b3.if_req = 1;
        for (int k = 0; k < 30 && lat3 < 0; k++) begin
            @(negedge clk);
            if (b3.if_ack) begin lat3 = k; d1 = b3.if_rdata; b3.if_req = 0; end
        end
        b3.if_req = 0;
        chk("r3 reissue latency", lat3, 5);
        chk("r3 reissue data", d1, 32'h1111_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
